bus_arbiter4: RTL
=================

// Module: bus_arbiter4
//
// PURPOSE
//  Round-robin arbiter and sequencer for a shared 8-bit data bus built on a 4:1 byte mux.
//  Four requesters (e.g. CPU, PPU, DMA, APU) raise req; the arbiter picks one owner and
//  drives its one-hot grant and 2-bit mux select, then registers the selected byte as bus_data.
//  Ownership is held across a burst while req or lock stays high, then passed fairly.
//
// PARAMETERS
//  MAX_HOLD  16  cycles an owner may hold the bus before forced release (ARB_TIMEOUT_EN only); 2..255
//
// PORTS
//  clk        in   1  system clock, all state updates on rising edge
//  reset_n    in   1  asynchronous active-low reset
//  req        in   4  req[i]=1: requester i wants the bus
//  lock       in   4  lock[i]=1: owner i keeps the bus even if req[i] drops
//  in0..in3   in   8  requester write bytes, selected by sel
//  grant      out  4  one-hot owner, registered; 4'b0000 when idle
//  sel        out  2  encoded owner index, registered; drives the 4:1 byte mux
//  bus_data   out  8  registered byte of current owner
//  bus_valid  out  1  bus_data holds a real transfer this cycle
//  timeout    out  1  1-cycle pulse on forced release
//
// BEHAVIOUR
//  - Reset (reset_n=0, async): grant=0, sel=0, bus_data=0, bus_valid=0, timeout=0,
//    last=2'd3 (so req[0] wins first), hold_cnt=0, state=IDLE.
//  - States: IDLE (no owner), OWN (grant nonzero). grant never has more than one bit set.
//  - Winner search: scan indices last+1, last+2, last+3, last (mod 4); first with req=1 wins.
//  - IDLE: any req -> next edge grant=1<<w, sel=w, last=w, hold_cnt=0, ->OWN. Latency req->grant = 1 clk.
//  - OWN, owner o: keep while req[o]|lock[o]; hold_cnt saturates at 255.
//  - Release when req[o]=0 and lock[o]=0: same edge re-runs winner search over the other
//    requesters. Winner found -> direct handover (no idle cycle). None -> grant=0, ->IDLE.
//  - Previous owner re-requesting on release edge has lowest priority (scan ends at last).
//  - Data path: each edge, bus_data <= in[sel] and bus_valid <= (state==OWN) & req[sel].
//    Byte is one clk behind grant; bus_valid=0 while owner holds by lock only.
//    bus_data retains last value when bus_valid=0.
//  - Simultaneous req edges from several requesters: resolved by the scan above only.
//  - req/lock from non-owners have no effect while owned.
//  - Reset mid-burst: everything returns to reset values immediately.
//    No partial transfer is flagged valid after reset.
//
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in OWN, if hold_cnt reaches MAX_HOLD-1 and any other req is
//    high, force release even if lock[o]=1.
//    - Handover follows normal scan; timeout pulses 1 clk on the handover edge.
//    - If no other req, owner keeps the bus and hold_cnt saturates.
//  ARB_TIMEOUT_EN undefined: no counter logic, timeout tied 0, owner holds indefinitely.
//
// TESTING
//  1 reset with req=4'b1111 -> grant=0 during reset; first edge after release grant=0001, sel=0.
//  2 req=1111, each owner drops req after 1 beat -> grants 0001,0010,0100,1000,0001, no gaps.
//  3 owner 2, in2=8'hA5, req2 held 3 clks -> bus_data=A5 with bus_valid=1 for 3 clks, lagging grant by 1.
//  4 owner 1 lock=0010, req1 drops, req3 high -> grant stays 0010, bus_valid=0, until lock drops.
//    Then grant=1000 next edge.
//  5 ARB_TIMEOUT_EN, MAX_HOLD=4, owner 0 locked, req1 high -> after 4 clks grant=0010, timeout=1 for 1 clk.
//  6 reset_n low mid-burst of owner 3 -> grant, bus_valid, sel zero asynchronously.
//    After release, req3 alone -> grant=1000.

Source files
------------

// File: rtl/bus_arbiter4.sv
// Purpose    : 4-way round-robin bus arbiter with a registered 4:1 byte mux.
// Latency    : req -> grant 1 clk; grant -> bus_data/bus_valid 1 clk more.
// Backpressure: none; an owner keeps the bus while req|lock, others wait.
//
// Ports:
//   clk, reset_n     clock and async active-low reset
//   req[3:0]         per-requester bus request
//   lock[3:0]        owner keeps the bus even after its req drops
//   in0..in3[7:0]    requester write bytes, picked by sel
//   grant[3:0]       one-hot registered owner, 0 when idle
//   sel[1:0]         registered owner index driving the byte mux
//   bus_data[7:0]    registered byte of the current owner
//   bus_valid        bus_data carries a real transfer this cycle
//   timeout          1-cycle pulse on a forced release
//
// Build option: define ARB_TIMEOUT_EN to enable forced release after
// MAX_HOLD cycles of ownership when another requester is waiting.

module bus_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] lock,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [7:0] bus_data,
    output logic       bus_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Elaboration-time range check on the hold limit.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("bus_arbiter4: MAX_HOLD must be within 2..255");
    end

    state_t     state;
    logic [1:0] last;       // index of the most recent owner, scan starts after it
    logic       win_found;
    logic [1:0] win_idx;
    logic [7:0] sel_byte;
    logic       keep;
    logic       forced;

    // Round-robin search: last+1, last+2, last+3, last. Iterating from the
    // far end and overwriting leaves the nearest requester as the result.
    function automatic logic [2:0] scan(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign {win_found, win_idx} = scan(req, last);

    always_comb begin
        sel_byte = in0;
        case (sel)
            2'd0:    sel_byte = in0;
            2'd1:    sel_byte = in1;
            2'd2:    sel_byte = in2;
            default: sel_byte = in3;
        endcase
    end

    // Owner holds while it still requests or has locked the bus.
    assign keep = req[sel] | lock[sel];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;

    // Force a release only if somebody else is actually waiting; a lone
    // owner keeps the bus and its counter simply saturates.
    assign forced = (state == OWN) && (hold_cnt >= HOLD_LIMIT) && (|(req & ~grant));
`else
    assign forced = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            last      <= 2'd3;
            bus_data  <= 8'h00;
            bus_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
        end else begin
            // Data path runs off the owner registered last cycle, so the
            // byte trails grant by one clock. Lock-only cycles carry no data.
            bus_valid <= (state == OWN) && req[sel];
            if ((state == OWN) && req[sel]) begin
                bus_data <= sel_byte;
            end
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= OWN;
                        grant    <= 4'b0001 << win_idx;
                        sel      <= win_idx;
                        last     <= win_idx;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                OWN: begin
                    if (keep && !forced) begin
`ifdef ARB_TIMEOUT_EN
                        if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end else if (win_found) begin
                        // Direct handover; the old owner sits last in the
                        // scan so it can only win back if nobody else asks.
                        grant    <= 4'b0001 << win_idx;
                        sel      <= win_idx;
                        last     <= win_idx;
                        timeout  <= forced;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end else begin
                        state <= IDLE;
                        grant <= 4'b0000;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                end
            endcase
        end
    end

endmodule
